// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for two result sources (ALU, branch).
//
// Each source owns an in-order FIFO of DEPTH {tag,value} entries. Each cycle
// at most one candidate source is chosen round-robin. Its queue head is loaded
// into the registered broadcast outputs.
//
// Optional feature: define CDB_BYPASS_EN to let a winning source with an empty
// queue broadcast its accepted input directly, without enqueuing it.
//
// Ports:
//   clk               - clock, all state on rising edge
//   globalReset       - synchronous active-high reset (beats clear and requests)
//   clear             - flush: empties both queues, drops this cycle's requests
//   aluDataBusReq     - ALU result present;  aluRob / aluResult tag and value
//   aluGrant          - ALU queue has room (registered count only)
//   branchDataBusReq  - branch result present; branchRob / branchResult
//   branchGrant       - branch queue has room
//   validBroadcast    - CDB holds a valid result this cycle
//   robEntry / result - broadcast tag / value (held when not valid)
module cdb_arbiter #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned ROB   = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           globalReset,
    input  logic           clear,
    input  logic           aluDataBusReq,
    input  logic [ROB:0]   aluRob,
    input  logic [WIDTH:0] aluResult,
    output logic           aluGrant,
    input  logic           branchDataBusReq,
    input  logic [ROB:0]   branchRob,
    input  logic [WIDTH:0] branchResult,
    output logic           branchGrant,
    output logic           validBroadcast,
    output logic [ROB:0]   robEntry,
    output logic [WIDTH:0] result
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Source index 0 = ALU, 1 = branch.
    logic [ROB:0]   r_tag  [2][DEPTH];
    logic [WIDTH:0] r_val  [2][DEPTH];
    logic [PW-1:0]  r_head [2];
    logic [PW-1:0]  r_tail [2];
    logic [CW-1:0]  r_cnt  [2];
    logic           r_prio_br;  // 1: branch wins a conflict
    logic           r_valid;
    logic [ROB:0]   r_rob;
    logic [WIDTH:0] r_result;

    logic [1:0]     w_req;
    logic [ROB:0]   w_in_tag [2];
    logic [WIDTH:0] w_in_val [2];
    logic [1:0]     w_grant;
    logic [1:0]     w_acc;
    logic [1:0]     w_nonempty;
    logic [1:0]     w_cand;
    logic [1:0]     w_pop;
    logic [1:0]     w_push;
    logic           w_bcast;
    logic           w_sel;
    logic [ROB:0]   w_out_tag;
    logic [WIDTH:0] w_out_val;

    assign w_req       = {branchDataBusReq, aluDataBusReq};
    assign w_in_tag[0] = aluRob;
    assign w_in_tag[1] = branchRob;
    assign w_in_val[0] = aluResult;
    assign w_in_val[1] = branchResult;

    always_comb begin
        w_grant    = '0;
        w_acc      = '0;
        w_nonempty = '0;
        w_cand     = '0;
        w_pop      = '0;
        w_push     = '0;
        for (int s = 0; s < 2; s++) begin
            w_grant[s]    = r_cnt[s] < CW'(DEPTH);
            w_acc[s]      = w_req[s] && w_grant[s] && !clear;
            w_nonempty[s] = r_cnt[s] != '0;
            w_cand[s]     = w_nonempty[s] || (BYPASS && w_acc[s]);
        end
        // clear suppresses the broadcast even when queues are non-empty.
        w_bcast = (w_cand[0] || w_cand[1]) && !clear;
        w_sel   = w_cand[1] && (!w_cand[0] || r_prio_br);
        for (int s = 0; s < 2; s++) begin
            w_pop[s]  = w_bcast && (w_sel == s[0]) && w_nonempty[s];
            // A bypassed input goes straight to the bus and is never stored.
            w_push[s] = w_acc[s] && !(w_bcast && (w_sel == s[0]) && !w_nonempty[s]);
        end
        if (w_nonempty[w_sel]) begin
            w_out_tag = r_tag[w_sel][r_head[w_sel]];
            w_out_val = r_val[w_sel][r_head[w_sel]];
        end else begin
            w_out_tag = w_in_tag[w_sel];
            w_out_val = w_in_val[w_sel];
        end
    end

    // Control state: counts, pointers, priority and broadcast registers.
    always_ff @(posedge clk) begin
        if (globalReset) begin
            for (int s = 0; s < 2; s++) begin
                r_cnt[s]  <= '0;
                r_head[s] <= '0;
                r_tail[s] <= '0;
            end
            r_prio_br <= 1'b1;
            r_valid   <= 1'b0;
            r_rob     <= '0;
            r_result  <= '0;
        end else if (clear) begin
            for (int s = 0; s < 2; s++) begin
                r_cnt[s]  <= '0;
                r_head[s] <= '0;
                r_tail[s] <= '0;
            end
            r_valid <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_tail[s] <= (r_tail[s] == PW'(DEPTH - 1)) ? '0 : r_tail[s] + 1'b1;
                end
                if (w_pop[s]) begin
                    r_head[s] <= (r_head[s] == PW'(DEPTH - 1)) ? '0 : r_head[s] + 1'b1;
                end
                r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
            end
            r_valid <= w_bcast;
            if (w_bcast) begin
                r_rob     <= w_out_tag;
                r_result  <= w_out_val;
                r_prio_br <= !w_sel;
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the counts.
    always_ff @(posedge clk) begin
        if (!globalReset && !clear) begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_tag[s][r_tail[s]] <= w_in_tag[s];
                    r_val[s][r_tail[s]] <= w_in_val[s];
                end
            end
        end
    end

    assign aluGrant       = w_grant[0];
    assign branchGrant    = w_grant[1];
    assign validBroadcast = r_valid;
    assign robEntry       = r_rob;
    assign result         = r_result;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: random and directed stimulus, a queue-based
// reference model, and a scoreboard monitor that checks every broadcast
// against the expected edge, tag and value.
module tb_cdb_arbiter;

    localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        globalReset;
    logic        clear;
    logic        aluDataBusReq;
    logic [2:0]  aluRob;
    logic [31:0] aluResult;
    logic        aluGrant;
    logic        branchDataBusReq;
    logic [2:0]  branchRob;
    logic [31:0] branchResult;
    logic        branchGrant;
    logic        validBroadcast;
    logic [2:0]  robEntry;
    logic [31:0] result;

    cdb_arbiter #(.WIDTH(31), .ROB(2), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .globalReset      (globalReset),
        .clear            (clear),
        .aluDataBusReq    (aluDataBusReq),
        .aluRob           (aluRob),
        .aluResult        (aluResult),
        .aluGrant         (aluGrant),
        .branchDataBusReq (branchDataBusReq),
        .branchRob        (branchRob),
        .branchResult     (branchResult),
        .branchGrant      (branchGrant),
        .validBroadcast   (validBroadcast),
        .robEntry         (robEntry),
        .result           (result)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [2:0] tag; logic [31:0] val; } ent_t;
    typedef struct { int cyc; logic [2:0] tag; logic [31:0] val; } exp_t;

    ent_t qa[$];
    ent_t qb[$];
    exp_t exp_q[$];
    bit   prio_br = 1'b1;
    bit   alu_grant_dropped = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference model: advance one edge from the inputs currently driven.
    task automatic model_step();
        int   c;
        bit   ga, gb, aa, ab, ca, cb, wb;
        ent_t o;
        c = edge_cnt + 1;
        if (globalReset) begin
            qa.delete();
            qb.delete();
            prio_br = 1'b1;
            return;
        end
        ga = qa.size() < DEPTH;
        gb = qb.size() < DEPTH;
        check("aluGrant", {31'd0, aluGrant}, {31'd0, ga});
        check("branchGrant", {31'd0, branchGrant}, {31'd0, gb});
        if (clear) begin
            qa.delete();
            qb.delete();
            return;
        end
        aa = aluDataBusReq && ga;
        ab = branchDataBusReq && gb;
        ca = (qa.size() != 0) || (BYP && aa);
        cb = (qb.size() != 0) || (BYP && ab);
        if (ca || cb) begin
            wb = cb && (!ca || prio_br);
            if (wb) begin
                if (qb.size() != 0) o = qb.pop_front();
                else begin
                    o = '{branchRob, branchResult};
                    ab = 1'b0;
                end
                prio_br = 1'b0;
            end else begin
                if (qa.size() != 0) o = qa.pop_front();
                else begin
                    o = '{aluRob, aluResult};
                    aa = 1'b0;
                end
                prio_br = 1'b1;
            end
            exp_q.push_back('{c, o.tag, o.val});
        end
        if (aa) qa.push_back('{aluRob, aluResult});
        if (ab) qb.push_back('{branchRob, branchResult});
    endtask

    task automatic drive(input bit rst, input bit clr, input bit ra, input logic [2:0] ta,
                         input logic [31:0] va, input bit rb, input logic [2:0] tb,
                         input logic [31:0] vb);
        @(negedge clk);
        globalReset      = rst;
        clear            = clr;
        aluDataBusReq    = ra;
        aluRob           = ta;
        aluResult        = va;
        branchDataBusReq = rb;
        branchRob        = tb;
        branchResult     = vb;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
    endtask

    // Monitor: compare outputs after every edge against the scoreboard.
    logic [2:0]  last_tag = '0;
    logic [31:0] last_val = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (globalReset) begin
                check("rst_valid", {31'd0, validBroadcast}, 32'd0);
                check("rst_rob", {29'd0, robEntry}, 32'd0);
                check("rst_result", result, 32'd0);
                last_tag = '0;
                last_val = '0;
            end else begin
                while (exp_q.size() != 0 && exp_q[0].cyc < edge_cnt) begin
                    check("missed_broadcast_edge", edge_cnt, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() != 0 && exp_q[0].cyc == edge_cnt) begin
                    check("valid", {31'd0, validBroadcast}, 32'd1);
                    check("robEntry", {29'd0, robEntry}, {29'd0, exp_q[0].tag});
                    check("result", result, exp_q[0].val);
                    last_tag = exp_q[0].tag;
                    last_val = exp_q[0].val;
                    void'(exp_q.pop_front());
                end else begin
                    check("idle_valid", {31'd0, validBroadcast}, 32'd0);
                    check("hold_rob", {29'd0, robEntry}, {29'd0, last_tag});
                    check("hold_result", result, last_val);
                end
            end
        end
    end

    initial begin
        int ai;
        int pct, clr_pct;
        globalReset      = 1'b1;
        clear            = 1'b0;
        aluDataBusReq    = 1'b0;
        aluRob           = '0;
        aluResult        = '0;
        branchDataBusReq = 1'b0;
        branchRob        = '0;
        branchResult     = '0;
        model_step();
        drive(1, 0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);

        // Single ALU result, tag 3 value 0x55.
        drive(0, 0, 1, 3'd3, 32'h55, 0, 3'd0, 32'd0);
        idle(4);

        // Both sources after reset: branch first, then ALU.
        drive(1, 0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        drive(0, 0, 1, 3'd1, 32'h10, 1, 3'd2, 32'h20);
        idle(4);

        // ALU holds each tag until accepted while branch streams.
        ai = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, ai < 4, ai[2:0], 32'hA0 + ai, 1, 3'(i), 32'hB00 + i);
            if (!aluGrant) alu_grant_dropped = 1'b1;
            if (aluGrant && ai < 4) ai++;
        end
        check("alu_grant_dropped", {31'd0, alu_grant_dropped}, 32'd1);
        check("alu_all_accepted", ai, 4);
        idle(8);

        // Fill both queues, then clear with both requests high.
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 3'(i), 32'hC0 + i, 1, 3'(i + 4), 32'hD0 + i);
        drive(0, 1, 1, 3'd7, 32'hEE, 1, 3'd7, 32'hFF);
        idle(4);

        // Reset while queues hold entries and clear is high.
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 3'(i), 32'h1C0 + i, 1, 3'(i), 32'h1D0 + i);
        drive(1, 1, 1, 3'd5, 32'h99, 1, 3'd6, 32'h98);
        drive(0, 0, 1, 3'd1, 32'h111, 1, 3'd2, 32'h222);
        idle(4);

        // Randomized phases with varying load and occasional clear/reset.
        for (int ph = 0; ph < 8; ph++) begin
            pct     = (ph % 4 == 0) ? 95 : (ph % 4 == 1) ? 60 : (ph % 4 == 2) ? 30 : 10;
            clr_pct = (ph < 4) ? 0 : 3;
            for (int i = 0; i < 400; i++) begin
                drive($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < clr_pct,
                      $urandom_range(0, 99) < pct, 3'($urandom), $urandom,
                      $urandom_range(0, 99) < pct, 3'($urandom), $urandom);
            end
        end

        idle(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001 Parameter WIDTH, default 31: result MSB index; data is WIDTH+1 bits.
- REQ-002 Parameter ROB, default 2: ROB tag MSB index; tag is ROB+1 bits.
- REQ-003 Parameter DEPTH, default 2: entries per source queue; legal range 1..4.
- REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005 Port globalReset, input, 1: synchronous, active-high reset.
- REQ-006 Port clear, input, 1: pipeline flush (controlFlow[0]); discards all buffered results.
- REQ-007 Port aluDataBusReq, input, 1: ALU presents a result this cycle.
- REQ-008 Port aluRob, input, ROB+1: ROB tag of the ALU result.
- REQ-009 Port aluResult, input, WIDTH+1: ALU result value.
- REQ-010 Port aluGrant, output, 1: ALU queue can accept; high means aluDataBusReq is accepted this edge.
- REQ-011 Port branchDataBusReq, input, 1: branch unit presents a result this cycle.
- REQ-012 Port branchRob, input, ROB+1: ROB tag of the branch result.
- REQ-013 Port branchResult, input, WIDTH+1: branch result value.
- REQ-014 Port branchGrant, output, 1: branch queue can accept.
- REQ-015 Port validBroadcast, output, 1: common data bus holds a valid result this cycle.
- REQ-016 Port robEntry, output, ROB+1: ROB tag broadcast on the CDB.
- REQ-017 Port result, output, WIDTH+1: value broadcast on the CDB.

Function
- REQ-018 Each source SHALL own an in-order FIFO of DEPTH {tag,value} entries, with count, head and tail pointers that wrap modulo DEPTH.
- REQ-019 xGrant SHALL equal (count_x < DEPTH), computed from registered count only; it SHALL NOT depend on a same-cycle pop.
- REQ-020 A result is accepted at an edge iff xDataBusReq && xGrant; while grant is low, the source holds its request and the block ignores it.
- REQ-021 A source is a candidate when its queue is non-empty, or, with bypass (REQ-031), when its queue is empty and an accepted request is present.
- REQ-022 Per edge, the block SHALL select at most one candidate and load its head (or bypassed input) into registered outputs validBroadcast/robEntry/result.
- REQ-023 Selection SHALL be round-robin: on conflict, the source not granted most recently wins; the priority pointer SHALL flip only on a broadcast, to point away from the winner.
- REQ-024 With no candidate, validBroadcast SHALL be 0 next cycle; robEntry and result hold their last values.
- REQ-025 Simultaneous push and pop on the same queue SHALL leave count unchanged, including when count = DEPTH; a pop with no push decrements count.
- REQ-026 Output order per source SHALL equal acceptance order; no entry is dropped or duplicated except on clear or reset.
- REQ-027 clear SHALL take priority over all requests that edge: both queues are emptied, the request is not accepted, validBroadcast is 0 next cycle, and the priority pointer is unchanged.

Reset
- REQ-028 On globalReset at a rising edge: counts and pointers 0, validBroadcast 0, robEntry 0, result 0, priority pointer to branch.
- REQ-029 Reset mid-operation SHALL discard all queued entries; aluGrant and branchGrant read 1 in the cycle after reset.
- REQ-030 globalReset SHALL take precedence over clear and over all requests.

Configuration
- REQ-031 Macro CDB_BYPASS_EN: when defined, a winning source with an empty queue broadcasts its accepted input at the same edge, without enqueuing it (latency 1 edge). When undefined, every result is enqueued first (minimum latency 2 edges) and candidates come from non-empty queues only.

Verification
- REQ-032 Reset, then ALU req tag 3 value 0x55 for one cycle with bypass on -> validBroadcast=1, robEntry=3, result=0x55 after that edge; with bypass off, after the following edge.
- REQ-033 Both sources request in the same cycle after reset (ALU tag 1/0x10, branch tag 2/0x20) -> branch broadcasts first, ALU on the next cycle; pointer then favours branch.
- REQ-034 ALU holds req for 4 cycles with tags 0..3 while the branch unit streams continuously -> output alternates branch/ALU, ALU tags appear in order 0,1,2,3, and aluGrant drops to 0 when the ALU queue reaches 2 entries.
- REQ-035 Both queues full (DEPTH=2), assert clear with both reqs high -> validBroadcast=0 next cycle, both grants 1, and no stale tag is ever broadcast afterwards.
- REQ-036 globalReset asserted while both queues hold entries and clear is also high -> all outputs 0 next cycle, and the first request after reset wins per branch priority.
